// File: rtl/io_mmio_responder.sv
// io_mmio_responder: I/O-region load/store responder bridging the CPU to the
// UART tx/rx handshakes, a buffered RX FIFO and the cycle/instruction counters.
module io_mmio_responder #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_trans,
  input  logic        io_recv,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        instr_retire,
  output logic [31:0] rd_data,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CTRCLR = 8'h18;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

  logic [7:0]  offset;
  logic        unused_bits;

  tx_state_t   tx_state_q, tx_state_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic [7:0]  rx_mem_q [RX_DEPTH];
  logic [7:0]  rx_mem_d [RX_DEPTH];
  logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d;

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        tx_wr;
  logic        rx_full;
  logic        rx_nonempty;
  logic        rx_push;
  logic        rx_pop;
  logic        ctr_clr;
  logic [7:0]  rx_head;

  // Only the low byte of the address is decoded; upper data lanes are unused
  assign offset      = addr[7:0];
  assign unused_bits = ^{addr[31:8], wr_data[31:8]};

  assign rx_full     = (rx_count_q == CW'(RX_DEPTH));
  assign rx_nonempty = (rx_count_q != '0);
  assign rx_head     = rx_mem_q[rx_rd_ptr_q];

  assign tx_wr   = io_trans[0] && (offset == OFF_TXDATA);
  assign rx_push = uart_rx_valid && !rx_full;
  assign rx_pop  = io_recv && (offset == OFF_RXDATA) && rx_nonempty;
  assign ctr_clr = (io_trans != 4'b0000) && (offset == OFF_CTRCLR);

  assign uart_tx_valid = (tx_state_q == TX_FULL);
  assign uart_tx_data  = tx_data_q;
  assign uart_rx_ready = !rx_full;
  assign rd_data       = rd_data_q;

  // TX holding register: a write is only taken while empty, so a write that
  // coincides with the draining handshake is dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_EMPTY: begin
        if (tx_wr) begin
          tx_state_d = TX_FULL;
          tx_data_d  = wr_data[7:0];
        end
      end
      TX_FULL: begin
        if (uart_tx_ready) begin
          tx_state_d = TX_EMPTY;
        end
      end
      default: tx_state_d = TX_EMPTY;
    endcase
  end

  // RX FIFO next state: push and pop may happen together, leaving the count alone
  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = uart_rx_data;
      rx_wr_ptr_d           = rx_wr_ptr_q + PW'(1);
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  // Performance counters: a clear write wins over that cycle's increment
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = instr_cnt_q + {31'b0, instr_retire};
    if (ctr_clr) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end
  end

  // Load mux: captures pre-edge state on a read, otherwise holds
  always_comb begin
    rd_data_d = rd_data_q;
    if (io_recv) begin
      case (offset)
        OFF_STATUS: rd_data_d = {30'b0, rx_nonempty, !uart_tx_valid};
        OFF_RXDATA: rd_data_d = rx_nonempty ? {24'b0, rx_head} : 32'b0;
        OFF_CYCLE:  rd_data_d = cycle_cnt_q;
        OFF_INSTR:  rd_data_d = instr_cnt_q;
        default:    rd_data_d = 32'b0;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_EMPTY;
      tx_data_q   <= '0;
      rx_mem_q    <= '{default: '0};
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      rd_data_q   <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      rx_mem_q    <= rx_mem_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

endmodule

// File: doc/io_mmio_responder.md
# io_mmio_responder

Memory-mapped I/O responder for the RISC-V core. It sits on the I/O side of the load/store control path. It answers CPU stores qualified by `io_trans` and loads qualified by `io_recv` in the `0x8xxx_xxxx` region. It bridges those accesses to the UART transmit/receive handshakes, a buffered RX FIFO, and the cycle and instruction performance counters.

## Interface

Parameters:
- `RX_DEPTH`, default 4: RX FIFO entries; must be a power of two ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `io_trans`  in  4  store byte mask for an I/O address; already hazard-gated; nonzero means a write this cycle.
- `io_recv`  in  1  load strobe for an I/O address.
- `addr`  in  32  byte address; only `addr[7:0]` is decoded, and the caller guarantees `addr[31:28]` is `4'b1000`.
- `wr_data`  in  32  store data, already lane-shifted.
- `instr_retire`  in  1  one valid instruction retired this cycle.
- `rd_data`  out  32  registered load data.
- `uart_tx_data`  out  8  byte to transmitter.
- `uart_tx_valid`  out  1  tx byte valid.
- `uart_tx_ready`  in  1  transmitter accepts this cycle.
- `uart_rx_data`  in  8  byte from receiver.
- `uart_rx_valid`  in  1  rx byte valid.
- `uart_rx_ready`  out  1  FIFO can accept; equals `!full`, combinational from the count.

## Operation

Register map (offset = `addr[7:0]`):
- `0x00` status (RO): bit0 = tx holding empty (`!uart_tx_valid`); bit1 = RX FIFO non-empty; all other bits 0.
- `0x04` rx data (RO, read pops): `{24'b0, head}`. When the FIFO is empty, reads 0 and does not pop.
- `0x08` tx data (WO): requires `io_trans[0]`. Loads `wr_data[7:0]` into the holding register when the holding register is empty. When it is full, the write is dropped silently.
- `0x10` cycle counter (RO): increments every cycle.
- `0x14` instruction counter (RO): increments when `instr_retire` is high.
- `0x18` counter reset (WO): any nonzero `io_trans` clears both counters.
- Any other offset reads 0. Writes to RO or unmapped offsets are ignored.

TX holding register:
- Has two states: EMPTY (`uart_tx_valid` = 0) and FULL (`uart_tx_valid` = 1).
- EMPTY to FULL on an accepted tx write.
- FULL to EMPTY on `uart_tx_valid && uart_tx_ready`.
- A write arriving in the same cycle as a handshake is dropped, because status showed FULL.
- `uart_tx_data` stays stable while FULL.

RX FIFO:
- Push on `uart_rx_valid && uart_rx_ready`.
- Pop on `io_recv` at offset `0x04` when the FIFO is non-empty.
- Push and pop in the same cycle both occur and the count is unchanged. This is impossible when full, since `uart_rx_ready` is 0.
- Pointers are `log2(RX_DEPTH)` bits and wrap modulo `RX_DEPTH`. The count is `log2(RX_DEPTH)+1` bits.
- FIFO order is strict.

Counters:
- 32-bit; wrap from `0xFFFF_FFFF` to 0.
- A counter-reset write takes precedence over an increment in the same cycle: the counters are 0 after that edge.

## Timing

Reset (asynchronous, immediate while `rst` is high):
- `rd_data` = 0.
- `uart_tx_valid` = 0 and `uart_tx_data` = 0.
- FIFO empty, so `uart_rx_ready` = 1.
- Both counters = 0.

Loads:
- Latency is 1: `rd_data` is captured at the edge where `io_recv` = 1 and is valid the following cycle, matching the synchronous dmem read.
- `rd_data` holds its value when `io_recv` = 0.
- A counter read returns the value before that edge's increment.
- An rx read returns the head before that edge's pop.
- Status reflects state before the edge.

Stores:
- Take effect at the edge where `io_trans` is nonzero.
- A tx write makes `uart_tx_valid` = 1 in the next cycle.
- If `io_recv` and `io_trans` are both asserted, both are serviced.

Reset mid-operation:
- Discards the held tx byte and all FIFO contents.
- `uart_tx_valid` drops immediately, not waiting for a clock edge.

## Test plan

- Reset then read: assert and release `rst`, then read `0x00`. Next-cycle `rd_data` = `0x1`. `uart_rx_ready` = 1 and `uart_tx_valid` = 0.
- TX handshake and drop:
  - Write `0x41` to `0x08` with `uart_tx_ready` = 0. Next cycle `uart_tx_valid` = 1 and `uart_tx_data` = `0x41`.
  - A second write of `0x42` while FULL is dropped.
  - Raise `uart_tx_ready` for one cycle. `uart_tx_valid` = 0 after that edge and status bit0 = 1.
- RX FIFO fill and drain:
  - Push `0x11`, `0x22`, `0x33`, `0x44`. `uart_rx_ready` = 0 after the fourth push.
  - Five reads of `0x04` return `0x11`, `0x22`, `0x33`, `0x44`, then 0.
  - Status bit1 is 0 after the fourth pop.
- Simultaneous push and pop: with 2 entries, assert `uart_rx_valid` (`0x55`) and `io_recv` at `0x04` in the same cycle. The read returns the old head and the count stays 2. The order of the remaining bytes is preserved, with `0x55` last.
- Counters:
  - Run 10 cycles after reset with `instr_retire` high on 6 of them.
  - A read of `0x14` returns 6.
  - A write to `0x18` in the same cycle as `instr_retire` leaves both counters at 0 next cycle, then resumes counting.
  - Force the cycle counter to `0xFFFF_FFFF`; it wraps to 0.
- Async reset mid-transfer: assert `rst` between edges while `uart_tx_valid` = 1 and the FIFO holds 3 bytes. `uart_tx_valid` falls before the next edge, `uart_rx_ready` = 1, and a read of `0x04` returns 0.
